// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, instruction, FSM state types and the ALU reference model.
package alu_pkg;
   localparam int ALU_W = 8;
   localparam int ALU_REGS = 4;
   localparam int ALU_RA_W = $clog2(ALU_REGS);
   typedef enum logic [2:0] {
      OP_OR, OP_AND, OP_XOR, OP_NOTA, OP_ADD, OP_SUB, OP_INCA, OP_INCB
   } alu_op_e;
   typedef struct packed {
      alu_op_e opc;
      logic [ALU_RA_W-1:0] rd;
      logic [ALU_RA_W-1:0] ra;
      logic [ALU_RA_W-1:0] rb;
   } instr_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WB} ctrl_state_e;
   function automatic logic [ALU_W-1:0] alu_model(alu_op_e op, logic [ALU_W-1:0] a, logic [ALU_W-1:0] b);
      logic [ALU_W-1:0] r;
      r = '0;
      case (op)
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_XOR:  r = a ^ b;
         OP_NOTA: r = ~a;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_INCA: r = a + 1'b1;
         OP_INCB: r = b + 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: REG_COUNT x DATA_W registers, two async read ports, one sync write port, sync reset to zero.
module alu_regfile #(
   parameter int DATA_W = 8,
   parameter int REG_COUNT = 4,
   parameter int RA_W = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [RA_W-1:0]   raddr_b,
   output logic [DATA_W-1:0] rdata_b
);
   logic [DATA_W-1:0] mem [REG_COUNT];
   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
endmodule

// File: rtl/alu_controller.sv
// alu_controller: drives an external 8-op ALU from a register file and writes results back (IDLE->ISSUE->WB).
// Define ALU_CHECK_EN to compare alu_s against an internal model and raise sticky alu_err on mismatch.
module alu_controller
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_COUNT = 4,
   localparam int RA_W = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [RA_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3+3*RA_W-1:0] instr,
   output logic              alu_opc2,
   output logic              alu_opc1,
   output logic              alu_opc0,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_s,
   output logic              res_valid,
   output logic [RA_W-1:0]   res_rd,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zero,
   output logic              alu_err
);
   ctrl_state_e state, state_n;
   logic [2:0] opc_q;
   logic [RA_W-1:0] rd_q;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic accept, we;
   assign ld_ready = state == IDLE;
   assign instr_ready = state == IDLE && !ld_valid;
   assign accept = instr_valid && instr_ready;
   assign {alu_opc2, alu_opc1, alu_opc0} = opc_q;
   // load and writeback never overlap: loads only in IDLE, writeback only in WB
   assign we = (state == IDLE && ld_valid) || state == WB;
   alu_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .RA_W(RA_W)) u_regfile (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(state == WB ? res_rd : ld_addr),
      .wdata(state == WB ? res_data : ld_data),
      .raddr_a(instr[RA_W +: RA_W]),
      .rdata_a(rdata_a),
      .raddr_b(instr[0 +: RA_W]),
      .rdata_b(rdata_b)
   );
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? WB : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opc_q <= '0;
         rd_q <= '0;
         alu_a <= '0;
         alu_b <= '0;
         res_valid <= 1'b0;
         res_rd <= '0;
         res_data <= '0;
         res_zero <= 1'b1;
      end else begin
         state <= state_n;
         res_valid <= state == ISSUE;
         if (accept) begin
            opc_q <= instr[3*RA_W +: 3];
            rd_q <= instr[2*RA_W +: RA_W];
            alu_a <= rdata_a;
            alu_b <= rdata_b;
         end
         if (state == ISSUE) begin
            res_rd <= rd_q;
            res_data <= alu_s;
            res_zero <= alu_s == '0;
         end
      end
   end
`ifdef ALU_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) alu_err <= 1'b0;
      else if (state == ISSUE && alu_s != alu_model(alu_op_e'(opc_q), alu_a, alu_b)) alu_err <= 1'b1;
   end
`else
   assign alu_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: directed tests of the ALU controller against an external behavioural ALU.
module tb_alu_controller;
   logic clk = 0, rst = 1;
   logic ld_valid = 0, instr_valid = 0, corrupt = 0;
   logic ld_ready, instr_ready;
   logic [1:0] ld_addr = 0;
   logic [7:0] ld_data = 0;
   logic [8:0] instr = 0;
   logic alu_opc2, alu_opc1, alu_opc0;
   logic [7:0] alu_a, alu_b, alu_s, res_data, exp_s;
   logic res_valid, res_zero, alu_err;
   logic [1:0] res_rd;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      exp_s = 8'h00;
      case ({alu_opc2, alu_opc1, alu_opc0})
         3'd0: exp_s = alu_a | alu_b;
         3'd1: exp_s = alu_a & alu_b;
         3'd2: exp_s = alu_a ^ alu_b;
         3'd3: exp_s = ~alu_a;
         3'd4: exp_s = alu_a + alu_b;
         3'd5: exp_s = alu_a - alu_b;
         3'd6: exp_s = alu_a + 8'd1;
         default: exp_s = alu_b + 8'd1;
      endcase
   end
   assign alu_s = corrupt ? 8'h00 : exp_s;

   alu_controller dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_opc2(alu_opc2), .alu_opc1(alu_opc1), .alu_opc0(alu_opc0),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_zero(res_zero),
      .alu_err(alu_err)
   );

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      ld_valid = 1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_valid = 0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                         output logic v, output logic [7:0] d, output logic [1:0] r, output logic z,
                         output logic [2:0] opc_seen, output logic [7:0] a_seen, output logic [7:0] b_seen);
      int n = 0;
      instr = {op, rd, ra, rb}; instr_valid = 1; #1;
      while (!instr_ready && n < 10) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      instr_valid = 0;
      opc_seen = {alu_opc2, alu_opc1, alu_opc0}; a_seen = alu_a; b_seen = alu_b;
      @(posedge clk); #1;
      v = res_valid; d = res_data; r = res_rd; z = res_zero;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      logic saw;
      logic v, z; logic [7:0] d, a, b; logic [1:0] r; logic [2:0] o;
      repeat (2) @(posedge clk); #1;
      rst = 0;
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
      n_checks++; if (res_zero !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res: zero=%b valid=%b want 1/0", res_zero, res_valid); end
      load(2'd0, 8'h11); load(2'd1, 8'h22);
      instr = {3'd4, 2'd2, 2'd0, 2'd1}; instr_valid = 1;
      @(posedge clk); #1;
      instr_valid = 0; rst = 1; saw = 0;
      repeat (2) begin @(posedge clk); #1; saw |= res_valid; end
      rst = 0;
      repeat (3) begin @(posedge clk); #1; saw |= res_valid; end
      n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL reset_mid_issue_pulse: res_valid pulsed, want none"); end
      n_checks++; if (ld_ready !== 1'b1 || res_zero !== 1'b1) begin n_fail++; $display("FAIL reset_mid_issue_state: ld_ready=%b res_zero=%b want 1/1", ld_ready, res_zero); end
      n_checks++; if ({alu_opc2, alu_opc1, alu_opc0, alu_a, alu_b, res_data, res_rd} !== 29'd0) begin n_fail++; $display("FAIL reset_outputs: opc=%b a=%h b=%h data=%h rd=%0d want zeros", {alu_opc2, alu_opc1, alu_opc0}, alu_a, alu_b, res_data, res_rd); end
      run_op(3'd0, 2'd2, 2'd0, 2'd1, v, d, r, z, o, a, b);
      n_checks++; if (v !== 1'b1 || d !== 8'h00 || z !== 1'b1) begin n_fail++; $display("FAIL reset_regs_cleared: valid=%b data=%h zero=%b want 1/00/1", v, d, z); end
   endtask

   task automatic test_load_add;
      logic v, z; logic [7:0] d, a, b; logic [1:0] r; logic [2:0] o;
      load(2'd0, 8'h0F); load(2'd1, 8'hF0);
      run_op(3'd4, 2'd2, 2'd0, 2'd1, v, d, r, z, o, a, b);
      n_checks++; if (a !== 8'h0F || b !== 8'hF0) begin n_fail++; $display("FAIL add_operands: a=%h b=%h want 0f/f0", a, b); end
      n_checks++; if (v !== 1'b1 || r !== 2'd2 || d !== 8'hFF || z !== 1'b0) begin n_fail++; $display("FAIL add_result: valid=%b rd=%0d data=%h zero=%b want 1/2/ff/0", v, r, d, z); end
      run_op(3'd0, 2'd3, 2'd2, 2'd2, v, d, r, z, o, a, b);
      n_checks++; if (d !== 8'hFF || r !== 2'd3) begin n_fail++; $display("FAIL add_writeback: data=%h rd=%0d want ff/3", d, r); end
   endtask

   task automatic test_wrap;
      logic v, z; logic [7:0] d, a, b; logic [1:0] r; logic [2:0] o;
      load(2'd0, 8'hFF);
      run_op(3'd6, 2'd3, 2'd0, 2'd0, v, d, r, z, o, a, b);
      n_checks++; if (d !== 8'h00 || z !== 1'b1) begin n_fail++; $display("FAIL wrap_inc: data=%h zero=%b want 00/1", d, z); end
      load(2'd0, 8'h00); load(2'd1, 8'h01);
      run_op(3'd5, 2'd3, 2'd0, 2'd1, v, d, r, z, o, a, b);
      n_checks++; if (d !== 8'hFF || z !== 1'b0) begin n_fail++; $display("FAIL wrap_sub: data=%h zero=%b want ff/0", d, z); end
   endtask

   task automatic test_tie_busy;
      ld_valid = 1; ld_addr = 2'd0; ld_data = 8'h05;
      instr = {3'd4, 2'd2, 2'd0, 2'd1}; instr_valid = 1; #1;
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL tie_ready: instr_ready=%b want 0", instr_ready); end
      @(posedge clk); #1;
      ld_valid = 0; #1;
      n_checks++; if (ld_ready !== 1'b1 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL tie_still_idle: ld_ready=%b instr_ready=%b want 1/1", ld_ready, instr_ready); end
      @(posedge clk); #1;
      n_checks++; if (ld_ready !== 1'b0 || instr_ready !== 1'b0 || alu_a !== 8'h05) begin n_fail++; $display("FAIL busy_issue: ld_ready=%b instr_ready=%b a=%h want 0/0/05", ld_ready, instr_ready, alu_a); end
      @(posedge clk); #1;
      n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h06 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL busy_wb: valid=%b data=%h instr_ready=%b want 1/06/0", res_valid, res_data, instr_ready); end
      @(posedge clk); #1;
      n_checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL busy_back_idle: valid=%b instr_ready=%b want 0/1", res_valid, instr_ready); end
      @(posedge clk); #1;
      instr_valid = 0;
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL busy_reaccept: ld_ready=%b want 0", ld_ready); end
      @(posedge clk); #1;
      n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h06) begin n_fail++; $display("FAIL busy_second: valid=%b data=%h want 1/06", res_valid, res_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_all_ops;
      logic v, z; logic [7:0] d, a, b; logic [1:0] r; logic [2:0] o;
      logic [7:0] exp_tab [8] = '{8'hBD, 8'h24, 8'h99, 8'h5A, 8'hE1, 8'h69, 8'hA6, 8'h3D};
      load(2'd0, 8'hA5); load(2'd1, 8'h3C);
      for (int i = 0; i < 8; i++) begin
         run_op(3'(i), 2'd2, 2'd0, 2'd1, v, d, r, z, o, a, b);
         n_checks++; if (v !== 1'b1 || d !== exp_tab[i] || o !== 3'(i)) begin n_fail++; $display("FAIL op%0d: valid=%b data=%h opc=%b want 1/%h/%b", i, v, d, o, exp_tab[i], 3'(i)); end
      end
      run_op(3'd4, 2'd0, 2'd0, 2'd1, v, d, r, z, o, a, b);
      run_op(3'd0, 2'd2, 2'd0, 2'd0, v, d, r, z, o, a, b);
      n_checks++; if (d !== 8'hE1) begin n_fail++; $display("FAIL rd_eq_ra: data=%h want e1", d); end
      n_checks++; if (alu_err !== 1'b0) begin n_fail++; $display("FAIL err_clean: alu_err=%b want 0", alu_err); end
   endtask

   task automatic test_alu_check;
      logic v, z; logic [7:0] d, a, b; logic [1:0] r; logic [2:0] o;
      logic exp_err;
`ifdef ALU_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      load(2'd0, 8'h01); load(2'd1, 8'h00);
      corrupt = 1;
      run_op(3'd0, 2'd2, 2'd0, 2'd1, v, d, r, z, o, a, b);
      corrupt = 0;
      n_checks++; if (d !== 8'h00 || alu_err !== exp_err) begin n_fail++; $display("FAIL check_mismatch: data=%h err=%b want 00/%b", d, alu_err, exp_err); end
      run_op(3'd4, 2'd2, 2'd0, 2'd0, v, d, r, z, o, a, b);
      n_checks++; if (d !== 8'h02 || alu_err !== exp_err) begin n_fail++; $display("FAIL check_sticky: data=%h err=%b want 02/%b", d, alu_err, exp_err); end
      rst = 1; @(posedge clk); #1; rst = 0;
      n_checks++; if (alu_err !== 1'b0) begin n_fail++; $display("FAIL check_reset: err=%b want 0", alu_err); end
   endtask

   initial begin
      test_reset;
      test_load_add;
      test_wrap;
      test_tie_busy;
      test_all_ops;
      test_alu_check;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
